// File: rtl/eth_pkg.sv
// eth_pkg: shared link-speed types and MII divider constants for the RGMII TX path
// Contents: link_speed_t, nib_t, per-speed period/low-phase constants,
// and helpers that map a raw speed code to the enum and look up P/L per speed.
package eth_pkg;
  typedef enum logic [1:0] {SPEED_10M = 2'b00, SPEED_100M = 2'b01, SPEED_1G = 2'b10} link_speed_t;
  typedef enum logic {NIB_LO = 1'b0, NIB_HI = 1'b1} nib_t;
  localparam logic [6:0] P_10M  = 7'd50;
  localparam logic [6:0] P_100M = 7'd5;
  localparam logic [6:0] L_10M  = 7'd25;
  localparam logic [6:0] L_100M = 7'd3;
  // The reserved code 11 is folded into 1G so it can never be distinguished downstream.
  function automatic link_speed_t to_speed(input logic [1:0] s);
    return s[1] ? SPEED_1G : link_speed_t'(s);
  endfunction
  function automatic logic [6:0] period(input link_speed_t s);
    return (s == SPEED_10M) ? P_10M : (s == SPEED_100M) ? P_100M : 7'd1;
  endfunction
  function automatic logic [6:0] low_len(input link_speed_t s);
    return (s == SPEED_10M) ? L_10M : (s == SPEED_100M) ? L_100M : 7'd0;
  endfunction
endpackage

// File: rtl/mii_tx_clk_div.sv
// mii_tx_clk_div: MII TX clock divider with nibble-select state
// Ports: clk_125/reset (sync, active-high); i_speed = speed for the coming cycle;
// i_clr = restart the divider (speed change); o_lvl = TX clock level,
// o_nib = high nibble selected, o_eop = byte-end strobe. All outputs describe
// the state the counter will hold after the next edge, so the top can register them.
module mii_tx_clk_div
  import eth_pkg::*;
(
  input  logic        clk_125,
  input  logic        reset,
  input  link_speed_t i_speed,
  input  logic        i_clr,
  output logic        o_lvl,
  output logic        o_nib,
  output logic        o_eop
);
  logic [6:0] r_div, w_div_nxt, w_last;
  nib_t       r_nib, w_nib_nxt;
  logic       w_hold;
  always_ff @(posedge clk_125) begin
    if (reset) begin
      r_div <= '0;
      r_nib <= NIB_LO;
    end else begin
      r_div <= w_div_nxt;
      r_nib <= w_nib_nxt;
    end
  end
  always_comb begin
    w_last    = period(i_speed) - 7'd1;
    w_hold    = i_clr || (i_speed == SPEED_1G);
    w_div_nxt = (w_hold || r_div == w_last) ? 7'd0 : r_div + 7'd1;
    w_nib_nxt = w_hold ? NIB_LO : (r_div == w_last) ? ((r_nib == NIB_LO) ? NIB_HI : NIB_LO) : r_nib;
    o_lvl     = w_div_nxt >= low_len(i_speed);
    o_nib     = w_nib_nxt == NIB_HI;
    o_eop     = (w_div_nxt == w_last) && (w_nib_nxt == NIB_HI);
  end
endmodule

// File: rtl/rgmii_tx_rate_adapter.sv
// rgmii_tx_rate_adapter: TX MAC byte stream to RGMII DDR slots at 10/100/1000 Mbps
// Ports: clk_125, reset (sync, active-high); link_speed from the RX speed detector;
// mac_tx_data/dv/er in, mac_tx_rdy capture strobe out; txc_*/txd_*/txctl_* DDR slot
// values; mii_mode high at 10M/100M.
// Build option: define RGMII_TX_ER_EN to propagate mac_tx_er onto txctl_fall.
module rgmii_tx_rate_adapter
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int NIBBLE_WIDTH = 4
) (
  input  logic                    clk_125,
  input  logic                    reset,
  input  logic [1:0]              link_speed,
  input  logic [DATA_WIDTH-1:0]   mac_tx_data,
  input  logic                    mac_tx_dv,
  input  logic                    mac_tx_er,
  output logic                    mac_tx_rdy,
  output logic                    txc_rise,
  output logic                    txc_fall,
  output logic [NIBBLE_WIDTH-1:0] txd_rise,
  output logic [NIBBLE_WIDTH-1:0] txd_fall,
  output logic                    txctl_rise,
  output logic                    txctl_fall,
  output logic                    mii_mode
);
`ifdef RGMII_TX_ER_EN
  localparam logic ER_EN = 1'b1;
`else
  localparam logic ER_EN = 1'b0;
`endif
  link_speed_t             r_speed, w_speed_nxt;
  logic [DATA_WIDTH-1:0]   r_data, w_data_nxt;
  logic [NIBBLE_WIDTH-1:0] w_lo, w_hi, w_nib_d;
  logic                    r_dv, r_er, w_dv_nxt, w_er_nxt;
  logic                    w_g, w_lvl, w_nib, w_eop;
  // Every register loads the value belonging to the cycle after the edge, so the
  // outputs line up with the divider state they describe.
  always_comb begin
    w_data_nxt  = mac_tx_rdy ? mac_tx_data : r_data;
    w_dv_nxt    = mac_tx_rdy ? mac_tx_dv : r_dv;
    w_er_nxt    = mac_tx_rdy ? (mac_tx_er & ER_EN) : r_er;
    w_speed_nxt = (mac_tx_rdy && !mac_tx_dv) ? to_speed(link_speed) : r_speed;
    w_g         = w_speed_nxt == SPEED_1G;
    w_lo        = w_data_nxt[NIBBLE_WIDTH-1:0];
    w_hi        = w_data_nxt[DATA_WIDTH-1:NIBBLE_WIDTH];
    w_nib_d     = w_nib ? w_hi : w_lo;
  end
  mii_tx_clk_div u_div (
    .clk_125 (clk_125),
    .reset   (reset),
    .i_speed (w_speed_nxt),
    .i_clr   (w_speed_nxt != r_speed),
    .o_lvl   (w_lvl),
    .o_nib   (w_nib),
    .o_eop   (w_eop)
  );
  always_ff @(posedge clk_125) begin
    if (reset) begin
      r_speed    <= SPEED_1G;
      r_data     <= '0;
      r_dv       <= 1'b0;
      r_er       <= 1'b0;
      mac_tx_rdy <= 1'b0;
      txc_rise   <= 1'b0;
      txc_fall   <= 1'b0;
      txd_rise   <= '0;
      txd_fall   <= '0;
      txctl_rise <= 1'b0;
      txctl_fall <= 1'b0;
      mii_mode   <= 1'b0;
    end else begin
      r_speed    <= w_speed_nxt;
      r_data     <= w_data_nxt;
      r_dv       <= w_dv_nxt;
      r_er       <= w_er_nxt;
      mac_tx_rdy <= w_g ? 1'b1 : w_eop;
      // At 1G the clock only starts once a byte has actually been captured.
      txc_rise   <= w_g ? mac_tx_rdy : w_lvl;
      txc_fall   <= w_g ? 1'b0 : w_lvl;
      txd_rise   <= !w_dv_nxt ? '0 : w_g ? w_lo : w_nib_d;
      txd_fall   <= !w_dv_nxt ? '0 : w_g ? w_hi : w_nib_d;
      txctl_rise <= w_dv_nxt;
      txctl_fall <= w_dv_nxt ^ w_er_nxt;
      mii_mode   <= !w_g;
    end
  end
endmodule
